// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the sequence detector event path.
//   TS_W_DEF  : default bit-position timestamp width
//   DEPTH_DEF : default event FIFO depth (power of two, >= 2)
//   CNT_W_DEF : default saturating match counter width
//   clog2()   : ceiling log2, usable in parameter expressions
package seq_det_pkg;

   localparam int TS_W_DEF  = 8;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Synchronous FIFO holding event timestamps.
//   clk, reset  : clock, synchronous active-high reset
//   clr         : synchronous soft clear (same effect as reset)
//   push, din   : write request and data; accepted when not full or when a pop frees a slot
//   pop         : remove head; ignored when empty
//   dout        : head entry, read straight out of the storage registers
//   full, empty : occupancy flags
//   level       : occupancy 0..DEPTH
module evt_sync_fifo
   import seq_det_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int W     = TS_W_DEF,
   localparam int PTR_W = clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a pop in the same edge frees the slot, so a full FIFO can still take a push
   assign do_push = push & (~full | do_pop);
   // storage is cleared on reset/clr so the head reads 0 until the first push
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/det_event_logger.sv
// Timestamps each rising edge of the sequence detector output z and queues the stamps.
//   clk, reset  : clock, synchronous active-high reset (highest priority)
//   en          : stream active; bit position advances and z is sampled
//   clr         : synchronous soft clear of counters, FIFO and overflow
//   z           : detector output, one bit per clock
//   out_valid/out_ready/out_data : timestamp stream from the FIFO head
//   fifo_level  : FIFO occupancy 0..DEPTH
//   event_cnt   : saturating count of all events, dropped ones included
//   overflow    : sticky, set when an event found the FIFO full with no pop
module det_event_logger
   import seq_det_pkg::*;
#(
   parameter  int TS_W  = TS_W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int CNT_W = CNT_W_DEF,
   localparam int LVL_W = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TS_W-1:0]  out_data,
   output logic [LVL_W-1:0] fifo_level,
   output logic [CNT_W-1:0] event_cnt,
   output logic             overflow
);

   logic [TS_W-1:0] bit_pos;
   logic            z_q;
   logic            evt;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop_ok;

   // z_q only follows z while the stream is active, so a pause never fakes an edge
   assign evt       = en & z & ~z_q;
   assign out_valid = ~fifo_empty;
   assign pop_ok    = out_ready & ~fifo_empty;

   // clr reaches the FIFO directly, so an event coincident with clr is discarded
   evt_sync_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .push  (evt),
      .pop   (out_ready),
      .din   (bit_pos),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         bit_pos   <= '0;
         z_q       <= 1'b0;
         event_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (en) begin
            bit_pos <= bit_pos + TS_W'(1);
            z_q     <= z;
         end
         if (evt && (event_cnt != '1)) event_cnt <= event_cnt + CNT_W'(1);
         // a simultaneous pop makes room, so only full-without-pop drops the stamp
         if (evt && fifo_full && !pop_ok) overflow <= 1'b1;
      end
   end

endmodule
